// File: rtl/audio_note_sequencer.sv
// Note sequencer: buffers (frequency, duration) commands in a FIFO and plays them back through freq_o.
// Optional macro NOTE_GAP_EN inserts one silent tick between consecutive notes.
module audio_note_sequencer #(
    parameter int DEPTH    = 16,
    parameter int TICK_DIV = 12000,
    parameter int FW       = 8,
    parameter int DW       = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [FW-1:0]          wr_freq,
    input  logic [DW-1:0]          wr_dur,
    input  logic                   start,
    input  logic                   stop,
    output logic [FW-1:0]          freq_o,
    output logic                   busy,
    output logic                   done,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

`ifdef NOTE_GAP_EN
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY} state_t;
`endif

    logic [FW+DW-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic             r_full;
    logic             r_empty;
    logic             r_overflow;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [FW-1:0]    r_freq;
    logic [FW-1:0]    w_freq_nxt;
    logic [DW-1:0]    r_cnt;
    logic [DW-1:0]    w_cnt_nxt;
    logic [PW-1:0]    r_presc;
    logic [PW-1:0]    w_presc_nxt;
    logic             r_done;
    logic             w_done_nxt;

    logic             w_push;
    logic             w_pop;
    logic [LW-1:0]    w_level_nxt;
    logic [FW+DW-1:0] w_head;
    logic [FW-1:0]    w_head_freq;
    logic [DW-1:0]    w_head_dur;

    // A pop never frees space for a write in the same cycle.
    assign w_push      = wr_en && !r_full;
    assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);
    assign w_head      = r_mem[r_rptr];
    assign w_head_freq = w_head[FW+DW-1:DW];
    assign w_head_dur  = w_head[DW-1:0];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {wr_freq, wr_dur};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LEVEL_FULL);
            r_empty <= (w_level_nxt == '0);
            if (wr_en && r_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_freq  <= '0;
            r_cnt   <= '0;
            r_presc <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_freq  <= w_freq_nxt;
            r_cnt   <= w_cnt_nxt;
            r_presc <= w_presc_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // stop overrides every transition; the FIFO is left untouched.
    always_comb begin
        w_state_nxt = r_state;
        w_freq_nxt  = r_freq;
        w_cnt_nxt   = r_cnt;
        w_presc_nxt = r_presc;
        w_done_nxt  = 1'b0;
        w_pop       = 1'b0;
        if (stop) begin
            w_state_nxt = S_IDLE;
            w_freq_nxt  = '0;
            w_cnt_nxt   = '0;
            w_presc_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_freq_nxt = '0;
                    if (start && !r_empty) begin
                        w_state_nxt = S_LOAD;
                    end
                end
                S_LOAD: begin
                    w_pop = 1'b1;
                    if (w_head_dur != '0) begin
                        w_freq_nxt  = w_head_freq;
                        w_cnt_nxt   = w_head_dur;
                        w_presc_nxt = '0;
                        w_state_nxt = S_PLAY;
                    end else begin
                        w_freq_nxt = '0;
                        if (r_level > LW'(1)) begin
                            w_state_nxt = S_LOAD;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                S_PLAY: begin
                    if (r_presc == PRESC_MAX) begin
                        w_presc_nxt = '0;
                        w_cnt_nxt   = r_cnt - DW'(1);
                        if (r_cnt == DW'(1)) begin
                            if (!r_empty) begin
`ifdef NOTE_GAP_EN
                                w_state_nxt = S_GAP;
                                w_freq_nxt  = '0;
`else
                                w_state_nxt = S_LOAD;
`endif
                            end else begin
                                w_state_nxt = S_IDLE;
                                w_freq_nxt  = '0;
                                w_done_nxt  = 1'b1;
                            end
                        end
                    end else begin
                        w_presc_nxt = r_presc + PW'(1);
                    end
                end
`ifdef NOTE_GAP_EN
                S_GAP: begin
                    if (r_presc == PRESC_MAX) begin
                        w_presc_nxt = '0;
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_presc_nxt = r_presc + PW'(1);
                    end
                end
`endif
                default: begin
                    w_state_nxt = S_IDLE;
                    w_freq_nxt  = '0;
                end
            endcase
        end
    end

    assign freq_o   = r_freq;
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign full     = r_full;
    assign empty    = r_empty;
    assign level    = r_level;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_audio_note_sequencer.sv
// Self-checking bench for audio_note_sequencer: a queue-based playback model compared every cycle,
// plus hand-computed timeline expectations for each directed scenario.
module tb_audio_note_sequencer;

    localparam int DEPTH    = 4;
    localparam int TICK_DIV = 4;
    localparam int FW       = 8;
    localparam int DW       = 8;
    localparam int HIST     = 40;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_PLAY = 2;
    localparam int M_GAP  = 3;

    typedef struct packed {
        logic [FW-1:0] freq;
        logic [DW-1:0] dur;
    } note_t;

    logic                   clk;
    logic                   reset;
    logic                   wr_en;
    logic [FW-1:0]          wr_freq;
    logic [DW-1:0]          wr_dur;
    logic                   start;
    logic                   stop;
    logic [FW-1:0]          freq_o;
    logic                   busy;
    logic                   done;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] level;
    logic                   overflow;

    int checks   = 0;
    int failures = 0;

    note_t      mQ[$];
    int         mMode  = M_IDLE;
    int         mLeft  = 0;
    logic [7:0] mFreq  = 8'h00;
    logic       mDone  = 1'b0;
    logic       mOvf   = 1'b0;
    logic       mValid = 1'b0;

    logic [7:0] histFreq [HIST];
    logic       histDone [HIST];
    logic       histBusy [HIST];

    audio_note_sequencer #(
        .DEPTH(DEPTH), .TICK_DIV(TICK_DIV), .FW(FW), .DW(DW)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_freq(wr_freq), .wr_dur(wr_dur),
        .start(start), .stop(stop), .freq_o(freq_o), .busy(busy), .done(done),
        .full(full), .empty(empty), .level(level), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Playback model: a note is a run of dur*TICK_DIV playing cycles, preceded by one load cycle.
    task automatic modelStep();
        int    sz;
        logic  doPush;
        note_t e;
        sz     = mQ.size();
        doPush = wr_en && (sz < DEPTH);
        mDone  = 1'b0;
        if (reset) begin
            mQ.delete();
            mMode  = M_IDLE;
            mLeft  = 0;
            mFreq  = 8'h00;
            mOvf   = 1'b0;
            mValid = 1'b1;
            return;
        end
        if (wr_en && sz == DEPTH) mOvf = 1'b1;
        if (stop) begin
            mMode = M_IDLE;
            mFreq = 8'h00;
            mLeft = 0;
        end else begin
            case (mMode)
                M_IDLE: if (start && sz > 0) mMode = M_LOAD;
                M_LOAD: begin
                    e = mQ.pop_front();
                    if (e.dur != 0) begin
                        mFreq = e.freq;
                        mLeft = int'(e.dur) * TICK_DIV;
                        mMode = M_PLAY;
                    end else begin
                        mFreq = 8'h00;
                        if (mQ.size() > 0) mMode = M_LOAD;
                        else begin
                            mMode = M_IDLE;
                            mDone = 1'b1;
                        end
                    end
                end
                M_PLAY: begin
                    mLeft--;
                    if (mLeft == 0) begin
                        if (sz > 0) begin
`ifdef NOTE_GAP_EN
                            mMode = M_GAP;
                            mFreq = 8'h00;
                            mLeft = TICK_DIV;
`else
                            mMode = M_LOAD;
`endif
                        end else begin
                            mMode = M_IDLE;
                            mFreq = 8'h00;
                            mDone = 1'b1;
                        end
                    end
                end
                M_GAP: begin
                    mLeft--;
                    if (mLeft == 0) mMode = M_LOAD;
                end
                default: mMode = M_IDLE;
            endcase
        end
        if (doPush) mQ.push_back({wr_freq, wr_dur});
    endtask

    // Model advances on the same edge the DUT samples its inputs.
    always @(posedge clk) modelStep();

    // Every settled cycle after the first reset, all outputs must match the model.
    always @(negedge clk) begin
        if (mValid) begin
            checkOutput("freq_o", 32'(freq_o), 32'(mFreq));
            checkOutput("busy", 32'(busy), 32'(mMode != M_IDLE));
            checkOutput("done", 32'(done), 32'(mDone));
            checkOutput("level", 32'(level), 32'(mQ.size()));
            checkOutput("full", 32'(full), 32'(mQ.size() == DEPTH));
            checkOutput("empty", 32'(empty), 32'(mQ.size() == 0));
            checkOutput("overflow", 32'(overflow), 32'(mOvf));
        end
    end

    task automatic applyStimulus(input logic we, input logic [7:0] f, input logic [7:0] d,
                                 input logic st, input logic sp);
        @(negedge clk);
        wr_en   = we;
        wr_freq = f;
        wr_dur  = d;
        start   = st;
        stop    = sp;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        wr_en = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Index 0 is the first settled cycle after the edge that sampled start.
    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            histFreq[i] = freq_o;
            histDone[i] = done;
            histBusy[i] = busy;
            wr_en = 1'b0;
            start = 1'b0;
            stop  = 1'b0;
        end
    endtask

    function automatic int countFreq(input int n, input logic [7:0] v);
        int c = 0;
        for (int i = 0; i < n; i++) if (histFreq[i] == v) c++;
        return c;
    endfunction

    function automatic int firstFreq(input int n, input logic [7:0] v);
        for (int i = 0; i < n; i++) if (histFreq[i] == v) return i;
        return -1;
    endfunction

    function automatic int firstDone(input int n);
        for (int i = 0; i < n; i++) if (histDone[i]) return i;
        return -1;
    endfunction

    function automatic int countDone(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (histDone[i]) c++;
        return c;
    endfunction

    function automatic int countBusy(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (histBusy[i]) c++;
        return c;
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time=%0t limit=200000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_freq = 8'h00;
        wr_dur  = 8'h00;
        start   = 1'b0;
        stop    = 1'b0;
        doReset();
        checkOutput("rst_freq", 32'(freq_o), 32'h0);
        checkOutput("rst_level", 32'(level), 32'h0);
        checkOutput("rst_empty", 32'(empty), 32'h1);
        checkOutput("rst_busy", 32'(busy), 32'h0);

        // Single three-tick note.
        applyStimulus(1'b1, 8'h40, 8'd3, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        watch(20);
        checkOutput("s1_first40", 32'(firstFreq(20, 8'h40)), 32'd1);
        checkOutput("s1_len40", 32'(countFreq(20, 8'h40)), 32'd12);
        checkOutput("s1_doneIdx", 32'(firstDone(20)), 32'd13);
        checkOutput("s1_doneCnt", 32'(countDone(20)), 32'd1);
        checkOutput("s1_busyEnd", 32'(histBusy[14]), 32'h0);

        // Back-to-back notes, including a rest.
        doReset();
        applyStimulus(1'b1, 8'h10, 8'd1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h20, 8'd2, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h00, 8'd1, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        watch(32);
`ifdef NOTE_GAP_EN
        checkOutput("s2_len10", 32'(countFreq(32, 8'h10)), 32'd4);
        checkOutput("s2_len20", 32'(countFreq(32, 8'h20)), 32'd8);
        checkOutput("s2_first20", 32'(firstFreq(32, 8'h20)), 32'd10);
        checkOutput("s2_doneIdx", 32'(firstDone(32)), 32'd27);
`else
        checkOutput("s2_len10", 32'(countFreq(32, 8'h10)), 32'd5);
        checkOutput("s2_len20", 32'(countFreq(32, 8'h20)), 32'd9);
        checkOutput("s2_first20", 32'(firstFreq(32, 8'h20)), 32'd6);
        checkOutput("s2_doneIdx", 32'(firstDone(32)), 32'd19);
`endif
        checkOutput("s2_doneCnt", 32'(countDone(32)), 32'd1);

        // Overflow, then a write colliding with a pop while full.
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h11 + i), 8'd1, 1'b0, 1'b0);
        idleCycles(1);
        checkOutput("s3_level", 32'(level), 32'd4);
        checkOutput("s3_full", 32'(full), 32'h1);
        checkOutput("s3_ovf", 32'(overflow), 32'h1);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h66, 8'd1, 1'b0, 1'b0);
        idleCycles(1);
        checkOutput("s3_levelPop", 32'(level), 32'd3);
        checkOutput("s3_fullPop", 32'(full), 32'h0);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        idleCycles(1);
        checkOutput("s3_busyStop", 32'(busy), 32'h0);
        checkOutput("s3_levelStop", 32'(level), 32'd3);

        // Zero-duration entry is skipped.
        doReset();
        applyStimulus(1'b1, 8'h30, 8'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h50, 8'd1, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        watch(12);
        checkOutput("s4_first50", 32'(firstFreq(12, 8'h50)), 32'd2);
        checkOutput("s4_len50", 32'(countFreq(12, 8'h50)), 32'd4);
        checkOutput("s4_len30", 32'(countFreq(12, 8'h30)), 32'd0);
        checkOutput("s4_doneIdx", 32'(firstDone(12)), 32'd6);

        // stop mid-note, then resume with the remaining note.
        doReset();
        applyStimulus(1'b1, 8'h21, 8'd2, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h22, 8'd1, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        idleCycles(3);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        idleCycles(1);
        checkOutput("s5_freqStop", 32'(freq_o), 32'h0);
        checkOutput("s5_busyStop", 32'(busy), 32'h0);
        checkOutput("s5_doneStop", 32'(done), 32'h0);
        checkOutput("s5_levelStop", 32'(level), 32'd1);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        watch(10);
        checkOutput("s5_first22", 32'(firstFreq(10, 8'h22)), 32'd1);
        checkOutput("s5_len22", 32'(countFreq(10, 8'h22)), 32'd4);
        checkOutput("s5_doneIdx", 32'(firstDone(10)), 32'd5);

        // start on an empty FIFO, then reset during playback.
        doReset();
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        watch(6);
        checkOutput("s6_emptyBusy", 32'(countBusy(6)), 32'd0);
        checkOutput("s6_emptyDone", 32'(countDone(6)), 32'd0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h44 + i), 8'd2, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        idleCycles(3);
        checkOutput("s6_preFreq", 32'(freq_o), 32'h44);
        checkOutput("s6_preOvf", 32'(overflow), 32'h1);
        doReset();
        checkOutput("s6_rstFreq", 32'(freq_o), 32'h0);
        checkOutput("s6_rstLevel", 32'(level), 32'd0);
        checkOutput("s6_rstOvf", 32'(overflow), 32'h0);
        checkOutput("s6_rstBusy", 32'(busy), 32'h0);
        idleCycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
